ahb_slave_arbiter: RTL and testbench

- Per-slave arbiter sitting directly downstream of the per-master address decoders; one instance per slave port.
- Collects the hreq bit for this slave from every master's decoder and grants exactly one master at a time, honouring AHB burst boundaries and hready.
- Drives the slave's hsel and the address/data-phase master indices consumed by the slave-side address and write-data muxes.

---
 rtl/ahb_slave_arbiter_pkg.sv | 41 ++++
 rtl/ahb_rr_picker.sv | 37 +++
 rtl/ahb_slave_arbiter.sv | 137 +++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types and helpers for the per-slave arbiter.
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'd0,
        TransBusy   = 2'd1,
        TransNonseq = 2'd2,
        TransSeq    = 2'd3
    } htrans_type;

    typedef enum logic [2:0] {
        BurstSingle = 3'd0,
        BurstIncr   = 3'd1,
        BurstWrap4  = 3'd2,
        BurstIncr4  = 3'd3,
        BurstWrap8  = 3'd4,
        BurstIncr8  = 3'd5,
        BurstWrap16 = 3'd6,
        BurstIncr16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbOwn,
        ArbLast
    } arb_state_type;

    // Beats in a burst; 0 means unbounded INCR.
    function automatic logic [4:0] burst_beats(hburst_type burst);
        logic [4:0] beats;
        case (burst)
            BurstSingle:             beats = 5'd1;
            BurstIncr:               beats = 5'd0;
            BurstWrap4, BurstIncr4:  beats = 5'd4;
            BurstWrap8, BurstIncr8:  beats = 5'd8;
            default:                 beats = 5'd16;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating priority encoder: first requester at or after ptr_i, with wrap-around.
// AHB_ARB_FIXED_PRIO_EN pins the scan start to index 0 (fixed priority).
module ahb_rr_picker #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned MIDX_WIDTH = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] req_i,
    input  logic [MIDX_WIDTH-1:0] ptr_i,
    output logic [MIDX_WIDTH-1:0] idx_o,
    output logic                  valid_o
);

    logic [MIDX_WIDTH-1:0] base;
    logic [MIDX_WIDTH-1:0] cand;

`ifdef AHB_ARB_FIXED_PRIO_EN
    logic [MIDX_WIDTH-1:0] unused_ptr;
    assign unused_ptr = ptr_i;
    assign base       = '0;
`else
    assign base = ptr_i;
`endif

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            cand = MIDX_WIDTH'((32'(base) + i) % MASTER_NUM);
            if (!valid_o && req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: burst-aware grant, hsel and address/data-phase master index.
// Define AHB_ARB_FIXED_PRIO_EN for fixed (lowest index wins) instead of round-robin.
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned MIDX_WIDTH = $clog2(MASTER_NUM)
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic [MASTER_NUM-1:0]      hreq,
    input  logic [MASTER_NUM-1:0][1:0] htrans,
    input  logic [MASTER_NUM-1:0][2:0] hburst,
    input  logic                       hready,
    output logic [MASTER_NUM-1:0]      hgrant,
    output logic [MIDX_WIDTH-1:0]      hmaster,
    output logic [MIDX_WIDTH-1:0]      hmaster_data,
    output logic                       hsel
);

    arb_state_type         state_q, state_d;
    logic [MASTER_NUM-1:0] hgrant_q, hgrant_d;
    logic [MIDX_WIDTH-1:0] hmaster_q, hmaster_d;
    logic [MIDX_WIDTH-1:0] hmaster_data_q, hmaster_data_d;
    logic [MIDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [4:0]            beat_cnt_q, beat_cnt_d;
    logic                  burst_open_q, burst_open_d;

    logic [MIDX_WIDTH-1:0] win_idx;
    logic                  win_valid;
    htrans_type            owner_trans;
    logic                  owner_req;
    logic [4:0]            beats;
    logic                  rearb;

    ahb_rr_picker #(
        .MASTER_NUM (MASTER_NUM),
        .MIDX_WIDTH (MIDX_WIDTH)
    ) u_picker (
        .req_i   (hreq),
        .ptr_i   (rr_ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign owner_trans = htrans_type'(htrans[hmaster_q]);
    assign owner_req   = hreq[hmaster_q];
    assign hsel        = hgrant_q[hmaster_q] & owner_req &
                         ((owner_trans == TransNonseq) || (owner_trans == TransSeq));

    // beat_cnt holds beats still to come in a fixed burst; 0 with burst_open means INCR.
    always_comb begin
        state_d        = state_q;
        hgrant_d       = hgrant_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        rr_ptr_d       = rr_ptr_q;
        beat_cnt_d     = beat_cnt_q;
        burst_open_d   = burst_open_q;
        rearb          = 1'b0;
        beats          = burst_beats(hburst_type'(hburst[hmaster_q]));

        if (hready) begin
            hmaster_data_d = hmaster_q;
            unique case (state_q)
                ArbIdle: rearb = 1'b1;
                ArbOwn, ArbLast: begin
                    if (hsel && owner_trans == TransNonseq) begin
                        if (beats == 5'd1) begin
                            rearb = 1'b1;
                        end else begin
                            beat_cnt_d   = (beats == 5'd0) ? 5'd0 : beats - 5'd1;
                            burst_open_d = 1'b1;
                            state_d      = ArbOwn;
                        end
                    end else if (hsel && owner_trans == TransSeq) begin
                        if (beat_cnt_q == 5'd1) begin
                            rearb = 1'b1;
                        end else if (beat_cnt_q != 5'd0) begin
                            beat_cnt_d = beat_cnt_q - 5'd1;
                            state_d    = (beat_cnt_q == 5'd2) ? ArbLast : ArbOwn;
                        end
                    end else if (!owner_req && !(burst_open_q && beat_cnt_q != 5'd0)) begin
                        rearb = 1'b1;
                    end else if (burst_open_q && beat_cnt_q == 5'd0 &&
                                 owner_trans == TransIdle) begin
                        rearb = 1'b1;
                    end
                end
                default: state_d = ArbIdle;
            endcase

            if (rearb) begin
                beat_cnt_d   = 5'd0;
                burst_open_d = 1'b0;
                if (win_valid) begin
                    state_d   = ArbOwn;
                    hmaster_d = win_idx;
                    hgrant_d  = MASTER_NUM'(1) << win_idx;
`ifdef AHB_ARB_FIXED_PRIO_EN
                    rr_ptr_d  = '0;
`else
                    rr_ptr_d  = (win_idx == MIDX_WIDTH'(MASTER_NUM - 1)) ? '0 : win_idx + 1'b1;
`endif
                end else begin
                    state_d  = ArbIdle;
                    hgrant_d = '0;
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q        <= ArbIdle;
            hgrant_q       <= '0;
            hmaster_q      <= '0;
            hmaster_data_q <= '0;
            rr_ptr_q       <= '0;
            beat_cnt_q     <= 5'd0;
            burst_open_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            hgrant_q       <= hgrant_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            rr_ptr_q       <= rr_ptr_d;
            beat_cnt_q     <= beat_cnt_d;
            burst_open_q   <= burst_open_d;
        end
    end

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: directed bursts, a per-cycle reference model and literal checks.
module tb_ahb_slave_arbiter;

    localparam int N = 4;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3;
    localparam logic [2:0] B_INCR8 = 3'd5, B_INCR16 = 3'd7;

    logic              hclk   = 1'b0;
    logic              hreset = 1'b1;
    logic [N-1:0]      hreq   = '0;
    logic [N-1:0][1:0] htrans = '0;
    logic [N-1:0][2:0] hburst = '0;
    logic              hready = 1'b1;
    logic [N-1:0]      hgrant;
    logic [1:0]        hmaster;
    logic [1:0]        hmaster_data;
    logic              hsel;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Reference model: owner (-1 = none), last owner index, data-phase index, rr pointer,
    // open burst kind (0 none, 1 INCR, 2 fixed), beats done / total of the fixed burst.
    int m_owner = -1, m_hmaster = 0, m_mdata = 0, m_ptr = 0;
    int m_kind = 0, m_done = 0, m_total = 0;

    ahb_slave_arbiter #(.MASTER_NUM(N)) dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .hreq         (hreq),
        .htrans       (htrans),
        .hburst       (hburst),
        .hready       (hready),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hsel         (hsel)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int beats_of(logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic int pick(int ptr, logic [N-1:0] rq);
        for (int k = 0; k < N; k++) begin
            if (rq[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge hclk or posedge hreset) begin : model_blk
        int own, hm, ptr, kind, done, total, w, n;
        bit rel, acc;
        logic [1:0] t;
        if (hreset) begin
            m_owner <= -1; m_hmaster <= 0; m_mdata <= 0; m_ptr <= 0;
            m_kind  <= 0;  m_done    <= 0; m_total <= 0;
        end else if (hready) begin
            own = m_owner; hm = m_hmaster; ptr = m_ptr;
            kind = m_kind; done = m_done; total = m_total;
            rel = 1'b0;
            if (own < 0) begin
                rel = 1'b1;
            end else begin
                t   = htrans[own];
                acc = hreq[own] && (t == T_NSEQ || t == T_SEQ);
                if (acc && t == T_NSEQ) begin
                    n = beats_of(hburst[own]);
                    if (n == 1) rel = 1'b1;
                    else if (n == 0) kind = 1;
                    else begin kind = 2; total = n; done = 1; end
                end else if (acc && kind == 2) begin
                    done++;
                    if (done == total) rel = 1'b1;
                end else if (!acc) begin
                    if (kind == 1 && (!hreq[own] || t == T_IDLE)) rel = 1'b1;
                    if (kind == 0 && !hreq[own]) rel = 1'b1;
                end
            end
            if (rel) begin
                kind = 0;
`ifdef AHB_ARB_FIXED_PRIO_EN
                w = pick(0, hreq);
`else
                w = pick(ptr, hreq);
`endif
                if (w >= 0) begin
                    own = w;
                    hm  = w;
`ifndef AHB_ARB_FIXED_PRIO_EN
                    ptr = (w + 1) % N;
`endif
                end else begin
                    own = -1;
                end
            end
            m_mdata <= m_hmaster;
            m_owner <= own; m_hmaster <= hm; m_ptr <= ptr;
            m_kind  <= kind; m_done <= done; m_total <= total;
        end
    end

    always @(negedge hclk) begin : compare_blk
        logic [N-1:0] eg;
        bit es;
        if (cmp_en) begin
            eg = '0;
            es = 1'b0;
            if (m_owner >= 0) begin
                eg = N'(1) << m_owner;
                es = hreq[m_owner] && (htrans[m_owner] == T_NSEQ || htrans[m_owner] == T_SEQ);
            end
            check("model_hgrant", 32'(hgrant), 32'(eg));
            check("model_hmaster", 32'(hmaster), 32'(m_hmaster));
            check("model_hmaster_data", 32'(hmaster_data), 32'(m_mdata));
            check("model_hsel", 32'(hsel), 32'(es));
        end
    end

    task automatic tick;
        @(posedge hclk);
        #2;
    endtask

    task automatic do_reset;
        hreset = 1'b1;
        hreq = '0; htrans = '0; hburst = '0; hready = 1'b1;
        tick(); tick();
        hreset = 1'b0;
    endtask

    task automatic set_m(input int m, input bit r, input logic [1:0] t, input logic [2:0] b);
        hreq[m] = r; htrans[m] = t; hburst[m] = b;
    endtask

    // Master m requests and runs n accepted beats; optional BUSY after beat busy_after and
    // hready held low for stall_len cycles while beat stall_at is presented.
    task automatic run_burst(input int m, input logic [2:0] b, input int n, input int busy_after,
                             input int stall_at, input int stall_len, input bit finish);
        int acc = 0, guard = 0, stall_left = stall_len;
        bit g, busy_done = 1'b0;
        set_m(m, 1'b1, T_NSEQ, b);
        while (acc < n && guard < 200) begin
            if (acc + 1 == stall_at && stall_left > 0) begin
                hready = 1'b0;
                stall_left--;
            end else begin
                hready = 1'b1;
            end
            g = hgrant[m] && hready && (htrans[m] == T_NSEQ || htrans[m] == T_SEQ);
            tick();
            guard++;
            if (g) begin
                acc++;
                if (acc == busy_after && !busy_done) begin
                    htrans[m] = T_BUSY;
                    busy_done = 1'b1;
                end else begin
                    htrans[m] = T_SEQ;
                end
            end else if (htrans[m] == T_BUSY) begin
                htrans[m] = T_SEQ;
            end
        end
        hready = 1'b1;
        if (guard >= 200) check("burst_timeout", 32'(acc), 32'(n));
        if (finish) set_m(m, 1'b0, T_IDLE, B_SINGLE);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [N-1:0] order [5];

        // Reset values, then first grant one cycle after the request.
        tick(); tick();
        check("rst_hgrant", 32'(hgrant), 32'h0);
        check("rst_hmaster", 32'(hmaster), 32'h0);
        check("rst_hmaster_data", 32'(hmaster_data), 32'h0);
        check("rst_hsel", 32'(hsel), 32'h0);
        cmp_en = 1'b1;
        hreset = 1'b0;
        tick(); tick();
        check("idle_hgrant", 32'(hgrant), 32'h0);
        set_m(2, 1'b1, T_NSEQ, B_SINGLE);
        tick();
        check("first_hgrant", 32'(hgrant), 32'h4);
        check("first_hmaster", 32'(hmaster), 32'd2);
        #1 check("first_hsel", 32'(hsel), 32'h1);
        tick();
        check("regrant_hgrant", 32'(hgrant), 32'h4);
        check("first_hmaster_data", 32'(hmaster_data), 32'd2);
        set_m(2, 1'b0, T_IDLE, B_SINGLE);
        tick();
        check("release_idle", 32'(hgrant), 32'h0);

        // Masters 0 and 2 both INCR4.
        do_reset();
        set_m(2, 1'b1, T_NSEQ, B_INCR4);
        run_burst(0, B_INCR4, 4, 0, 0, 0, 1'b1);
        check("incr4_handover", 32'(hgrant), 32'h4);
        check("incr4_hmaster", 32'(hmaster), 32'd2);
        check("incr4_data_old", 32'(hmaster_data), 32'd0);
        run_burst(2, B_INCR4, 4, 0, 0, 0, 1'b1);
        check("incr4_data_new", 32'(hmaster_data), 32'd2);
        tick(); tick();

        // INCR8 from master 1 with BUSY and a 3-cycle stall; master 3 waits.
        do_reset();
        set_m(3, 1'b1, T_NSEQ, B_SINGLE);
        run_burst(1, B_INCR8, 8, 2, 5, 3, 1'b1);
`ifdef AHB_ARB_FIXED_PRIO_EN
        check("incr8_next", 32'(hgrant), 32'h2);
`else
        check("incr8_next", 32'(hgrant), 32'h8);
        check("incr8_hmaster", 32'(hmaster), 32'd3);
`endif
        check("incr8_data", 32'(hmaster_data), 32'd1);
        set_m(3, 1'b0, T_IDLE, B_SINGLE);
        tick(); tick();

        // All four masters issue SINGLE continuously.
        do_reset();
`ifdef AHB_ARB_FIXED_PRIO_EN
        order = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
        order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`endif
        for (int m = 0; m < N; m++) set_m(m, 1'b1, T_NSEQ, B_SINGLE);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("single_order%0d", k), 32'(hgrant), 32'(order[k]));
            check($sformatf("single_hsel%0d", k), 32'(hsel), 32'h1);
        end
        hreq = '0; htrans = '0;
        tick(); tick();

        // INCR from master 3 ends with IDLE; grant frozen while hready is low.
        do_reset();
        run_burst(3, B_INCR, 3, 0, 0, 0, 1'b0);
        check("incr_held", 32'(hgrant), 32'h8);
        set_m(3, 1'b0, T_IDLE, B_SINGLE);
        set_m(1, 1'b1, T_NSEQ, B_SINGLE);
        hready = 1'b0;
        tick();
        check("incr_frozen", 32'(hgrant), 32'h8);
        hready = 1'b1;
        tick();
        check("incr_release", 32'(hgrant), 32'h2);
        set_m(1, 1'b0, T_IDLE, B_SINGLE);
        tick(); tick();

        // Asynchronous reset during beat 7 of an INCR16.
        do_reset();
        run_burst(2, B_INCR16, 7, 0, 0, 0, 1'b0);
        #1 hreset = 1'b1;
        #1;
        check("async_hgrant", 32'(hgrant), 32'h0);
        check("async_hsel", 32'(hsel), 32'h0);
        check("async_hmaster", 32'(hmaster), 32'h0);
        set_m(2, 1'b0, T_IDLE, B_SINGLE);
        set_m(1, 1'b1, T_NSEQ, B_SINGLE);
        set_m(3, 1'b1, T_NSEQ, B_SINGLE);
        tick();
        hreset = 1'b0;
        tick();
        check("post_rst_grant", 32'(hgrant), 32'h2);
        check("post_rst_hmaster", 32'(hmaster), 32'd1);
        hreq = '0; htrans = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
